// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, T-state
// encoding and the bit layout of the internal control word.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_T7   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam int CW_W  = 12;
  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_CE = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_LB = 8;
  localparam int CW_SU = 9;
  localparam int CW_EU = 10;
  localparam int CW_LO = 11;

  typedef logic [CW_W-1:0] cw_t;

  // Instructions that take a memory operand through T5.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sap_controller_step_sync.sv
// Advance qualifier: free-run passes every cycle, single-step passes only
// the first cycle of each STEP high level.
module step_sync (
  input  logic clk,
  input  logic clr_n,
  input  logic run,
  input  logic step,
  output logic adv
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign adv = run | (step & ~step_q);

endmodule

// File: rtl/sap_controller.sv
// SAP control sequencer: T-state fetch/execute machine with a programmable
// wait for the clocked ALU, driving the bus computer's control word.
module sap_controller #(
  parameter int ALU_LAT = 1
) (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic [3:0] IR_op,
  input  logic       RUN,
  input  logic       STEP,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       LB,
  output logic       SU,
  output logic       EU,
  output logic       LO,
  output logic [2:0] T_STATE,
  output logic       HALTED
);

  import sap_pkg::*;

  localparam logic [2:0] LAT_LAST = (ALU_LAT == 0) ? 3'd0 : 3'(ALU_LAT - 1);

  state_t     state, state_next;
  logic [2:0] wait_cnt, wait_cnt_next;
  logic       adv;
  logic       is_sub;
  cw_t        cw;

  step_sync u_step_sync (
    .clk   (CLK),
    .clr_n (CLR_n),
    .run   (RUN),
    .step  (STEP),
    .adv   (adv)
  );

  assign is_sub = (IR_op == OP_SUB);

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state    <= S_T1;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    if (adv) begin
      case (state)
        S_T1: state_next = S_T2;
        S_T2: state_next = S_T3;
        S_T3: state_next = S_T4;
        S_T4: begin
          if (is_mem_op(IR_op))       state_next = S_T5;
          else if (IR_op == OP_HLT)   state_next = S_HALT;
          else                        state_next = S_T1;
        end
        S_T5: begin
          if (IR_op == OP_ADD || IR_op == OP_SUB)
            state_next = (ALU_LAT == 0) ? S_T7 : S_T6;
          else
            state_next = S_T1;
        end
        S_T6: begin
          // Count stalled cycles out so the wait tracks ADV, not raw clocks.
          if (wait_cnt == LAT_LAST) begin
            state_next    = S_T7;
            wait_cnt_next = 3'd0;
          end else begin
            wait_cnt_next = wait_cnt + 3'd1;
          end
        end
        S_T7:    state_next = S_T1;
        S_HALT:  state_next = S_HALT;
        default: state_next = S_T1;
      endcase
    end
  end

  // Enables follow the state alone; load/count strobes are qualified by adv.
  always_comb begin
    cw = '0;
    case (state)
      S_T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = adv;
      end
      S_T2: cw[CW_CP] = adv;
      S_T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = adv;
      end
      S_T4: begin
        if (is_mem_op(IR_op)) begin
          cw[CW_EI] = 1'b1;
          cw[CW_LM] = adv;
        end else if (IR_op == OP_OUT) begin
          cw[CW_EA] = 1'b1;
          cw[CW_LO] = adv;
        end
      end
      S_T5: begin
        if (IR_op == OP_LDA) begin
          cw[CW_CE] = 1'b1;
          cw[CW_LA] = adv;
        end else if (IR_op == OP_ADD || IR_op == OP_SUB) begin
          cw[CW_CE] = 1'b1;
          cw[CW_LB] = adv;
          cw[CW_SU] = is_sub;
        end
      end
      S_T6: cw[CW_SU] = is_sub;
      S_T7: begin
        cw[CW_EU] = 1'b1;
        cw[CW_LA] = adv;
        cw[CW_SU] = is_sub;
      end
      default: cw = '0;
    endcase
    if (!CLR_n) cw = '0;
  end

  assign CP      = cw[CW_CP];
  assign EP      = cw[CW_EP];
  assign LM      = cw[CW_LM];
  assign CE      = cw[CW_CE];
  assign LI      = cw[CW_LI];
  assign EI      = cw[CW_EI];
  assign LA      = cw[CW_LA];
  assign EA      = cw[CW_EA];
  assign LB      = cw[CW_LB];
  assign SU      = cw[CW_SU];
  assign EU      = cw[CW_EU];
  assign LO      = cw[CW_LO];
  assign T_STATE = state;
  assign HALTED  = CLR_n & (state == S_HALT);

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench: three controllers (ALU_LAT 1, 3, 0) share RUN/STEP/CLR_n;
// an instruction-level model expands each opcode into its expected T-states.
module tb_sap_controller;

  localparam int NI = 3;

  localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200;
  localparam logic [11:0] M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040;
  localparam logic [11:0] M_LA = 12'h020, M_EA = 12'h010, M_LB = 12'h008;
  localparam logic [11:0] M_SU = 12'h004, M_EU = 12'h002, M_LO = 12'h001;

  typedef struct packed {
    logic [2:0]  t;
    logic [11:0] en;
    logic [11:0] ld;
    logic [3:0]  op;
  } ustep_t;

  typedef struct packed {
    int          inst;
    int          cyc;
    logic        chk_t;
    logic [2:0]  t;
    logic [11:0] cw;
    logic        h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_n, run, step;
  logic [3:0] ir_op [NI];
  logic       cp [NI], ep [NI], lm [NI], ce [NI], li [NI], ei [NI];
  logic       la [NI], ea [NI], lb [NI], su [NI], eu [NI], lo [NI];
  logic [2:0] ts [NI];
  logic       hl [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sap_controller #(.ALU_LAT(gi == 0 ? 1 : (gi == 1 ? 3 : 0))) u_dut (
      .CLK(clk), .CLR_n(clr_n), .IR_op(ir_op[gi]), .RUN(run), .STEP(step),
      .CP(cp[gi]), .EP(ep[gi]), .LM(lm[gi]), .CE(ce[gi]), .LI(li[gi]),
      .EI(ei[gi]), .LA(la[gi]), .EA(ea[gi]), .LB(lb[gi]), .SU(su[gi]),
      .EU(eu[gi]), .LO(lo[gi]), .T_STATE(ts[gi]), .HALTED(hl[gi])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  // Reference model state.
  ustep_t     plan [NI][16];
  int         p_len [NI];
  int         p_pos [NI];
  int         pc_m [NI];
  logic [3:0] ir_m [NI];
  logic [3:0] prog [16];
  logic       step_prev;
  int         cyc;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic put(input int k, input int t, input logic [11:0] en,
                     input logic [11:0] ld, input logic [3:0] op);
    plan[k][p_len[k]] = '{t: 3'(t), en: en, ld: ld, op: op};
    p_len[k]++;
  endtask

  // One instruction becomes its list of T-state visits.
  task automatic expand(input int k, input logic [3:0] op);
    logic [11:0] s;
    p_len[k] = 0;
    p_pos[k] = 0;
    put(k, 0, M_EP, M_LM, op);
    put(k, 1, 12'h0, M_CP, op);
    put(k, 2, M_CE, M_LI, op);
    case (op)
      4'b0000: begin
        put(k, 3, M_EI, M_LM, op);
        put(k, 4, M_CE, M_LA, op);
      end
      4'b0001, 4'b0010: begin
        s = (op == 4'b0010) ? M_SU : 12'h0;
        put(k, 3, M_EI, M_LM, op);
        put(k, 4, M_CE | s, M_LB, op);
        for (int i = 0; i < lat_of(k); i++) put(k, 5, s, 12'h0, op);
        put(k, 6, M_EU | s, M_LA, op);
      end
      4'b1110: put(k, 3, M_EA, M_LO, op);
      4'b1111: begin
        put(k, 3, 12'h0, 12'h0, op);
        put(k, 7, 12'h0, 12'h0, op);
      end
      default: put(k, 3, 12'h0, 12'h0, op);
    endcase
  endtask

  // Advance one clock: update the model with the inputs of the closing
  // cycle, then apply new inputs and queue the expected outputs.
  task automatic cycle(input logic c, input logic r, input logic s);
    logic  padv, adv;
    exp_t  e;
    ustep_t u;
    @(posedge clk);
    padv = run | (step & ~step_prev);
    for (int k = 0; k < NI; k++) begin
      if (!clr_n) begin
        p_len[k] = 0;
        p_pos[k] = 0;
        pc_m[k]  = 0;
      end else if (padv && plan[k][p_pos[k]].t != 3'd7) begin
        if (plan[k][p_pos[k]].t == 3'd2) ir_m[k] = plan[k][p_pos[k]].op;
        p_pos[k]++;
      end
      if (p_pos[k] >= p_len[k]) begin
        expand(k, prog[pc_m[k]]);
        pc_m[k] = (pc_m[k] + 1) % 16;
      end
    end
    step_prev = clr_n ? step : 1'b0;
    #1;
    clr_n = c;
    run   = r;
    step  = s;
    for (int k = 0; k < NI; k++) ir_op[k] = ir_m[k];
    adv = run | (step & ~step_prev);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      e.inst = k;
      e.cyc  = cyc;
      if (!clr_n) begin
        e.chk_t = 1'b0;
        e.t     = 3'd0;
        e.cw    = 12'h0;
        e.h     = 1'b0;
      end else begin
        u       = plan[k][p_pos[k]];
        e.chk_t = 1'b1;
        e.t     = u.t;
        e.h     = (u.t == 3'd7);
        e.cw    = u.en | (adv ? u.ld : 12'h0);
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {cp[e.inst], ep[e.inst], lm[e.inst], ce[e.inst], li[e.inst], ei[e.inst],
               la[e.inst], ea[e.inst], lb[e.inst], su[e.inst], eu[e.inst], lo[e.inst]};
        checks++;
        if (got !== e.cw) begin
          fails++;
          $display("FAIL cw inst%0d cyc%0d: got %03h expected %03h (CP EP LM CE LI EI LA EA LB SU EU LO)",
                   e.inst, e.cyc, got, e.cw);
        end
        checks++;
        if (hl[e.inst] !== e.h) begin
          fails++;
          $display("FAIL halted inst%0d cyc%0d: got %b expected %b", e.inst, e.cyc, hl[e.inst], e.h);
        end
        if (e.chk_t) begin
          checks++;
          if (ts[e.inst] !== e.t) begin
            fails++;
            $display("FAIL t_state inst%0d cyc%0d: got %0d expected %0d", e.inst, e.cyc, ts[e.inst], e.t);
          end
        end
      end
    end
  end

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 9))
      0, 1:    return 4'b0000;
      2, 3:    return 4'b0001;
      4, 5:    return 4'b0010;
      6:       return 4'b1110;
      7:       return 4'b0101;
      8:       return 4'($urandom_range(3, 13));
      default: return ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'b0101;
    endcase
  endfunction

  initial begin
    clr_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    step_prev = 1'b0;
    cyc = 0;
    for (int k = 0; k < NI; k++) begin
      ir_op[k] = 4'h0;
      ir_m[k]  = 4'h0;
      p_len[k] = 0;
      p_pos[k] = 0;
      pc_m[k]  = 0;
    end
    for (int i = 0; i < 16; i++) prog[i] = 4'b0101;

    // Program LDA / ADD / SUB / OUT / HLT in free-run, then sit in HALT.
    prog[0] = 4'b0000; prog[1] = 4'b0001; prog[2] = 4'b0010;
    prog[3] = 4'b1110; prog[4] = 4'b1111;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (55) cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);

    // ADD stream, reset while inside the ALU wait.
    for (int i = 0; i < 16; i++) prog[i] = 4'b0001;
    cycle(1'b0, 1'b1, 1'b0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (12) cycle(1'b1, 1'b1, 1'b0);

    // Single-step: held STEP advances once, then discrete pulses.
    for (int i = 0; i < 16; i++) prog[i] = (i % 2 == 0) ? 4'b0010 : 4'b0101;
    cycle(1'b0, 1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (12) begin
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
    end

    // Randomized programs, RUN/STEP patterns and occasional resets.
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 16; i++) prog[i] = rand_op();
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (100) begin
        cycle(($urandom_range(0, 79) != 0),
              ($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
